instr_mem_prog: RTL
===================

INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words; any value 2..65536.
REQ-002 Parameter ADDR_W, default 32: width of byte addresses on both ports.
REQ-003 Parameter DATA_W, default 32: instruction word width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 fetch_req  input  1  fetch request, sampled each cycle.
REQ-007 fetch_addr  input  ADDR_W  fetch byte address.
REQ-008 fetch_valid  output  1  instruction and fault outputs valid this cycle.
REQ-009 instruction  output  DATA_W  fetched word.
REQ-010 fault  output  2  fault code: 00 none, 01 misaligned, 10 out of range.
REQ-011 prog_we  input  1  program-port write strobe.
REQ-012 prog_addr  input  ADDR_W  program-port byte address.
REQ-013 prog_data  input  DATA_W  program-port write data.
REQ-014 ready  output  1  memory initialised; fetch and program ports accepted.

Function
REQ-015 Two states SHALL exist: CLEAR and READY; reset SHALL enter CLEAR with clear counter 0.
REQ-016 In CLEAR, one word per cycle SHALL be written to NOP_WORD (all zeros), at index = counter; the counter SHALL increment.
REQ-017 After the write of index DEPTH-1, the state SHALL become READY; ready SHALL assert the following cycle, exactly DEPTH cycles after reset release.
REQ-018 In CLEAR, fetch_req and prog_we SHALL be ignored; fetch_valid SHALL stay 0.
REQ-019 Word index SHALL be addr[ADDR_W-1:2]; addr[1:0] non-zero SHALL be misaligned.
REQ-020 Index >= DEPTH SHALL be out of range; misaligned SHALL take priority over out of range.
REQ-021 In READY, prog_we with an aligned, in-range address SHALL write prog_data at the next edge; faulting program writes SHALL be dropped silently.
REQ-022 Fetch latency SHALL be one cycle: fetch_req at edge N gives fetch_valid=1 with instruction and fault registered at edge N+1.
REQ-023 fetch_valid SHALL be 1 for exactly one cycle per accepted request; back-to-back requests SHALL yield back-to-back valid results.
REQ-024 A faulting fetch SHALL return instruction = NOP_WORD with the corresponding fault code and fetch_valid=1.
REQ-025 A fetch and a program write to the same index in the same cycle SHALL return the old contents (read-first).
REQ-026 When fetch_valid=0, instruction and fault SHALL hold their last values.

Reset
REQ-027 Asserting reset SHALL force ready=0, fetch_valid=0, instruction=0, fault=00, state=CLEAR and counter=0 immediately.
REQ-028 Reset asserted mid-clear or mid-fetch SHALL abort the operation and restart the full clear sequence on release; any pending fetch result SHALL be discarded.
REQ-029 Array contents SHALL not be reset directly; only the clear sequence SHALL initialise them.

Structure
REQ-030 Package instr_mem_pkg SHALL hold NOP_WORD, the fault-code constants (FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE) and the state typedef.
REQ-031 Storage SHALL be a sub-module instr_mem_array: one write port and one synchronous read-first port, with no reset, so that it maps to block RAM.
REQ-032 The FSM, address decode and fault logic SHALL reside in instr_mem_prog.

Verification
REQ-033 Reset pulse, DEPTH=1024 -> ready=0 for 1024 cycles, then 1; fetch of 0x0 returns 0x00000000 with fault 00.
REQ-034 Program 0x20080005 at 0x10, then fetch 0x10 -> one cycle later fetch_valid=1, instruction=0x20080005, fault=00.
REQ-035 Fetch 0x13 -> fault=01, instruction=0; fetch 0x1000 -> fault=10, instruction=0; program write to 0x1000 changes no word.
REQ-036 Same cycle: program 0xDEADBEEF at 0x20 and fetch 0x20 (old value 0x0) -> returns 0x0; next fetch returns 0xDEADBEEF.
REQ-037 Reset asserted at clear cycle 500 -> outputs 0 immediately; ready rises 1024 cycles after release; previously programmed words read 0.
REQ-038 Fetch requests 0x0, 0x4 and 0x8 on consecutive cycles -> three consecutive fetch_valid pulses in order, with the correct words.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared constants for the programmable instruction memory: the NOP fill word,
// fault codes, controller state encoding and the fault-priority helper.
package instr_mem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef logic [1:0] fault_t;
  localparam fault_t FAULT_NONE     = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_RANGE    = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // Misalignment wins over range so a bad low address never reads as a range error.
  function automatic fault_t fault_code(input logic misaligned, input logic out_of_range);
    if (misaligned)
      return FAULT_MISALIGN;
    else if (out_of_range)
      return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Word storage: one write port, one registered read-first read port, no reset,
// so the array maps onto block RAM.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Read and write share one block so a same-index collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
    if (rd_en)
      rd_data_reg <= mem[rd_idx];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: clears every word to NOP after reset, then
// serves one-cycle fetches and program-port writes with address fault checking.
module instr_mem_prog
  import instr_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [1:0]        fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              ready
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP_FILL = DATA_W'(NOP_WORD);

  // Port 0 is fetch, port 1 is program; both decode identically.
  logic [ADDR_W-1:0] port_addr  [2];
  logic [IDX_W-1:0]  port_idx   [2];
  fault_t            port_fault [2];

  assign port_addr[0] = fetch_addr;
  assign port_addr[1] = prog_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      logic [WIDX_W-1:0] word_idx;
      logic              misaligned;
      logic              out_of_range;

      assign word_idx          = port_addr[gi][ADDR_W-1:2];
      assign misaligned        = |port_addr[gi][1:0];
      assign out_of_range      = 64'(word_idx) >= 64'(DEPTH);
      assign port_idx[gi]      = word_idx[IDX_W-1:0];
      assign port_fault[gi]    = fault_code(misaligned, out_of_range);
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] clr_cnt_reg, clr_cnt_next;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == ST_CLEAR) begin
      if (clr_cnt_reg == LAST_IDX) begin
        state_next   = ST_READY;
        clr_cnt_next = '0;
      end else begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  logic is_ready;
  logic fetch_accept;
  logic fetch_hit;
  logic prog_accept;

  assign is_ready     = (state_reg == ST_READY);
  assign fetch_accept = is_ready & fetch_req;
  assign fetch_hit    = fetch_accept & (port_fault[0] == FAULT_NONE);
  assign prog_accept  = is_ready & prog_we & (port_fault[1] == FAULT_NONE);

  // While clearing, the write port belongs to the clear counter.
  logic              ram_wr_en;
  logic [IDX_W-1:0]  ram_wr_idx;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  assign ram_wr_en   = ~is_ready | prog_accept;
  assign ram_wr_idx  = is_ready ? port_idx[1] : clr_cnt_reg;
  assign ram_wr_data = is_ready ? prog_data : NOP_FILL;

  instr_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_idx  (ram_wr_idx),
    .wr_data (ram_wr_data),
    .rd_en   (fetch_hit),
    .rd_idx  (port_idx[0]),
    .rd_data (ram_rd_data)
  );

  logic   fetch_valid_reg;
  fault_t fault_reg;
  logic   rd_sel_reg;

  // rd_sel_reg picks RAM data only after a clean fetch; it also masks the
  // unreset RAM output until the first real read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid_reg <= 1'b0;
      fault_reg       <= FAULT_NONE;
      rd_sel_reg      <= 1'b0;
    end else begin
      fetch_valid_reg <= fetch_accept;
      if (fetch_accept) begin
        fault_reg  <= port_fault[0];
        rd_sel_reg <= (port_fault[0] == FAULT_NONE);
      end
    end
  end

  assign fetch_valid = fetch_valid_reg;
  assign fault       = fault_reg;
  assign instruction = rd_sel_reg ? ram_rd_data : NOP_FILL;
  assign ready       = is_ready;

endmodule
